// File: rtl/sp_bram_pkg.sv
//------------------------------------------------------------------------------
// sp_bram_pkg : shared types and SP address-bus layout for the BSRAM arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sp_bram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fsm_state_e;

    localparam int SramAdWidth    = 14;
    localparam int SramBeOffset   = 0;
    localparam int SramAddrOffset = 5;
    localparam int SramAddrBits   = SramAdWidth - SramAddrOffset;

    // Wide enough for the largest supported requester count (8).
    localparam int TagIdWidth = 3;

    typedef struct packed {
        logic                  valid;
        logic [TagIdWidth-1:0] id;
    } tag_t;

    // SP AD in 32-bit mode: word address in [13:5], bit 4 unused, byte enables in [3:0].
    function automatic logic [SramAdWidth-1:0] pack_ad(input logic [SramAddrBits-1:0] addr,
                                                       input logic [3:0]              be);
        logic [SramAdWidth-1:0] ad;
        ad = '0;
        ad[SramAddrOffset +: SramAddrBits] = addr;
        ad[SramBeOffset +: 4]              = be;
        return ad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick of the first request at/after ptr
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    always_comb begin
        int cand;
        cand    = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = 0; off < NumReq; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!valid_o && req_i[IdxW'(cand)]) begin
                valid_o              = 1'b1;
                idx_o                = IdxW'(cand);
                gnt_o[IdxW'(cand)]   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sp_bram_arbiter.sv
//------------------------------------------------------------------------------
// sp_bram_arbiter : round-robin sharing of one Gowin SP BSRAM (512x32)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sp_bram_arbiter
    import sp_bram_pkg::*;
#(
    parameter int NumPorts     = 4,
    parameter int AddrWidth    = 9,
    parameter int DataWidth    = 32,
    parameter int OutputReg    = 1,
    parameter int ClearOnReset = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumPorts-1:0]                  req_valid_i,
    output logic [NumPorts-1:0]                  req_ready_o,
    input  logic [NumPorts-1:0]                  req_we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   req_addr_i,
    input  logic [NumPorts-1:0][3:0]             req_be_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   req_wdata_i,
    output logic [NumPorts-1:0]                  rsp_valid_o,
    output logic [DataWidth-1:0]                 rsp_rdata_o,
    output logic                                 busy_o,
    output logic                                 sram_ce_o,
    output logic                                 sram_oce_o,
    output logic                                 sram_wre_o,
    output logic [SramAdWidth-1:0]               sram_ad_o,
    output logic [DataWidth-1:0]                 sram_di_o,
    output logic                                 sram_reset_o,
    input  logic [DataWidth-1:0]                 sram_do_i
);

    localparam int ID_W = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int LAT  = 1 + OutputReg;

    fsm_state_e            state_q;
    logic [AddrWidth-1:0]  cnt_q;
    logic [ID_W-1:0]       ptr_q;
    tag_t [LAT-1:0]        tag_q;
    tag_t [LAT-1:0]        tag_d;

    logic [NumPorts-1:0]   w_req;
    logic [NumPorts-1:0]   w_gnt;
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic                  w_any;
    tag_t                  w_tag_new;

    // Requests are invisible to the arbiter until the clear sequence is done.
    assign w_req = (state_q == RUN) ? req_valid_i : '0;

    rr_arbiter #(
        .NumReq (NumPorts),
        .IdxW   (ID_W)
    ) u_rr_arbiter (
        .req_i   (w_req),
        .ptr_i   (ptr_q),
        .gnt_o   (w_gnt),
        .idx_o   (w_idx),
        .valid_o (w_any)
    );

    assign req_ready_o = w_gnt;
    assign w_ptr_nxt   = (w_idx == ID_W'(NumPorts - 1)) ? '0 : w_idx + ID_W'(1);

    always_comb begin
        sram_ce_o  = 1'b0;
        sram_wre_o = 1'b0;
        sram_ad_o  = '0;
        sram_di_o  = '0;
        if (state_q == CLEAR) begin
            sram_ce_o  = 1'b1;
            sram_wre_o = 1'b1;
            sram_ad_o  = pack_ad(SramAddrBits'(cnt_q), 4'hF);
        end else if (w_any) begin
            sram_ce_o  = 1'b1;
            sram_wre_o = req_we_i[w_idx];
            sram_ad_o  = pack_ad(SramAddrBits'(req_addr_i[w_idx]),
                                 req_we_i[w_idx] ? req_be_i[w_idx] : 4'h0);
            sram_di_o  = req_wdata_i[w_idx];
        end
    end

    // Only reads occupy a response slot; writes push a bubble to keep timing aligned.
    assign w_tag_new = {w_any & ~req_we_i[w_idx], TagIdWidth'(w_idx)};

    generate
        if (LAT > 1) begin : g_tag_shift
            assign tag_d = {tag_q[LAT-2:0], w_tag_new};
        end else begin : g_tag_single
            assign tag_d = w_tag_new;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= (ClearOnReset != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
            ptr_q   <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + AddrWidth'(1);
                    if (cnt_q == '1) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (w_any) begin
                        ptr_q <= w_ptr_nxt;
                    end
                end
                default: state_q <= RUN;
            endcase
            tag_q <= tag_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (tag_q[LAT-1].valid) begin
            rsp_valid_o[tag_q[LAT-1].id[ID_W-1:0]] = 1'b1;
        end
    end

    assign rsp_rdata_o  = sram_do_i;
    assign busy_o       = (state_q == CLEAR);
    assign sram_oce_o   = 1'b1;
    assign sram_reset_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sp_bram_arbiter.sv
//------------------------------------------------------------------------------
// tb_sp_bram_arbiter : BSRAM model plus transaction-level reference for the arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sp_bram_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int OREG  = 1;
    localparam int CLR   = 1;
    localparam int L     = 1 + OREG;
    localparam int WORDS = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]          req_valid, req_we, req_ready, rsp_valid;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][3:0]     req_be;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [DW-1:0]          rsp_rdata, sram_di, sram_do;
    logic                   busy, sram_ce, sram_oce, sram_wre, sram_reset;
    logic [13:0]            sram_ad;

    sp_bram_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .OutputReg(OREG), .ClearOnReset(CLR)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
        .sram_ce_o(sram_ce), .sram_oce_o(sram_oce), .sram_wre_o(sram_wre),
        .sram_ad_o(sram_ad), .sram_di_o(sram_di), .sram_reset_o(sram_reset),
        .sram_do_i(sram_do)
    );

    // Behavioural SP block RAM: write at the edge, optional output register.
    logic [31:0] mem [WORDS];
    logic [31:0] dout1, dout2;
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_wre) begin
                for (int b = 0; b < 4; b++)
                    if (sram_ad[b]) mem[sram_ad[13:5]][8*b +: 8] <= sram_di[8*b +: 8];
            end else begin
                dout1 <= mem[sram_ad[13:5]];
            end
        end
        if (sram_oce) dout2 <= dout1;
    end
    assign sram_do = (OREG != 0) ? dout2 : dout1;

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] wd; } req_t;
    typedef struct { int due; int port; logic [31:0] data; } rsp_t;

    req_t        pq [NP][$];
    req_t        pend [NP];
    logic        pend_v [NP];
    rsp_t        rq [$];
    logic [31:0] shadow [WORDS];
    logic [31:0] last_rd [NP];
    int          exp_ptr, clr_cnt, cyc, busy_cycles;
    bit          exp_busy;
    int          n_assert, n_fail;
    int          fcnt [NP];
    int          ftot;
    bit          fair_on, p2_on;
    int          p2_first, p2_last, p2_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (!pend_v[p] && pq[p].size() > 0) begin
                pend[p]   = pq[p].pop_front();
                pend_v[p] = 1'b1;
            end
            req_valid[p] = pend_v[p];
            req_we[p]    = pend[p].we;
            req_addr[p]  = pend[p].addr;
            req_be[p]    = pend[p].be;
            req_wdata[p] = pend[p].wd;
        end
    endtask

    task automatic push_req(input int p, input logic we, input int addr, input logic [3:0] be,
                            input logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = AW'(addr); r.be = be; r.wd = wd;
        pq[p].push_back(r);
    endtask

    function automatic bit outstanding();
        bit o;
        o = exp_busy || (rq.size() != 0);
        for (int p = 0; p < NP; p++) if (pend_v[p] || pq[p].size() != 0) o = 1'b1;
        return o;
    endfunction

    // One clock: predict and check at the falling edge, advance, then re-drive inputs.
    task automatic cycle();
        int             g;
        int             a;
        logic [NP-1:0]  e_rdy, e_rv;
        @(negedge clk);
        g = -1;
        if (!exp_busy)
            for (int k = 0; k < NP; k++)
                if (g < 0 && pend_v[(exp_ptr + k) % NP]) g = (exp_ptr + k) % NP;
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(e_rdy));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (busy) busy_cycles++;
        if (exp_busy) begin
            chk("clr_ce_wre", {sram_ce, sram_wre}, 2'b11);
            chk("clr_ad", 64'(sram_ad), 64'(clr_cnt * 32 + 15));
            chk("clr_di", 64'(sram_di), 0);
            shadow[clr_cnt] = 32'h0;
            clr_cnt++;
            if (clr_cnt == WORDS) exp_busy = 1'b0;
        end else if (g >= 0) begin
            a = int'(pend[g].addr);
            chk("ce_wre", {sram_ce, sram_wre}, {1'b1, pend[g].we});
            chk("ad", 64'(sram_ad), 64'(a * 32 + (pend[g].we ? int'(pend[g].be) : 0)));
            if (pend[g].we) begin
                chk("di", 64'(sram_di), 64'(pend[g].wd));
                for (int b = 0; b < 4; b++)
                    if (pend[g].be[b]) shadow[a][8*b +: 8] = pend[g].wd[8*b +: 8];
            end else begin
                rq.push_back('{cyc + L, g, shadow[a]});
            end
            exp_ptr   = (g + 1) % NP;
            pend_v[g] = 1'b0;
        end else begin
            chk("idle_ce_wre", {sram_ce, sram_wre}, 2'b00);
        end
        e_rv = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rv[rq[0].port] = 1'b1;
            chk("rdata", 64'(rsp_rdata), 64'(rq[0].data));
            void'(rq.pop_front());
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        for (int p = 0; p < NP; p++) begin
            if (rsp_valid[p]) begin
                last_rd[p] = rsp_rdata;
                if (fair_on && ftot < 100) begin fcnt[p]++; ftot++; end
            end
        end
        if (p2_on && rsp_valid[2]) begin
            if (p2_n == 0) p2_first = cyc;
            p2_last = cyc;
            p2_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while (outstanding() && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(outstanding()), 0);
    endtask

    // Called just after a rising edge; asserts reset asynchronously mid-cycle.
    task automatic apply_reset();
        #3 rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin pend_v[p] = 1'b0; pq[p].delete(); end
        rq.delete();
        exp_ptr = 0; clr_cnt = 0; exp_busy = (CLR != 0); busy_cycles = 0;
        drive();
        repeat (2) begin
            @(negedge clk);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_ready", 64'(req_ready), 0);
            chk("rst_busy", 64'(busy), 64'(CLR));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; ftot = 0; fair_on = 0; p2_on = 0; p2_n = 0;
        p2_first = 0; p2_last = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int p = 0; p < NP; p++) begin
            pend_v[p] = 1'b0; pend[p] = '0; fcnt[p] = 0; last_rd[p] = '0;
        end
        drive();

        // Power-up reset and full clear
        @(posedge clk);
        #1;
        apply_reset();
        chk("oce_const", 64'(sram_oce), 1);
        chk("reset_const", 64'(sram_reset), 0);
        run_idle(600);
        chk("clear_length", 64'(busy_cycles), 512);

        // Cleared word reads back as zero
        push_req(3, 1'b0, 9'h1FF, 4'h0, 32'h0);
        run_idle(20);
        chk("clear_rd_1ff", 64'(last_rd[3]), 0);

        // Single-port write then read
        push_req(0, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF);
        push_req(0, 1'b0, 9'h010, 4'h0, 32'h0);
        run_idle(20);
        chk("rd_deadbeef", 64'(last_rd[0]), 64'h0DEADBEEF);

        // Byte-enable merge
        push_req(0, 1'b1, 9'h020, 4'hF, 32'h11223344);
        push_req(0, 1'b1, 9'h020, 4'b0101, 32'hAABBCCDD);
        push_req(0, 1'b0, 9'h020, 4'h0, 32'h0);
        run_idle(20);
        chk("be_merge", 64'(last_rd[0]), 64'h011BB33DD);

        // Random mixed traffic on a small address window to exercise read-after-write
        for (int i = 0; i < 200; i++)
            push_req($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                     4'($urandom_range(0, 15)), $urandom);
        run_idle(2000);

        // Back-to-back reads from one port
        for (int i = 0; i < 8; i++) push_req(1, 1'b1, i, 4'hF, $urandom);
        run_idle(50);
        p2_on = 1'b1;
        for (int i = 0; i < 8; i++) push_req(2, 1'b0, i, 4'h0, 32'h0);
        run_idle(50);
        p2_on = 1'b0;
        chk("tput_count", 64'(p2_n), 8);
        chk("tput_span", 64'(p2_last - p2_first), 7);

        // Fairness with all ports continuously requesting
        fair_on = 1'b1;
        for (int i = 0; i < 30; i++)
            for (int p = 0; p < NP; p++) push_req(p, 1'b0, $urandom_range(0, WORDS - 1), 4'h0, 32'h0);
        run_idle(300);
        fair_on = 1'b0;
        for (int p = 0; p < NP; p++) chk($sformatf("fair_port%0d", p), 64'(fcnt[p]), 25);

        // Reset with a read in flight, then reset again mid-clear
        push_req(1, 1'b0, 9'h005, 4'h0, 32'h0);
        drive();
        cycle();
        apply_reset();
        repeat (100) cycle();
        apply_reset();
        run_idle(600);
        chk("reclear_length", 64'(busy_cycles), 512);
        for (int p = NP - 1; p >= 0; p--) push_req(p, 1'b0, 9'h005, 4'h0, 32'h0);
        run_idle(30);
        chk("reclear_rd", 64'(last_rd[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sp_bram_arbiter.md
Name: sp_bram_arbiter

Overview:
- Shares one Gowin SP block RAM (32-bit mode, 512 words) between NumPorts requesters using round-robin arbitration.
- Accepts at most one read or write per cycle and drives the SP control, address and data pins directly.
- Tracks read latency with a tag pipeline and routes each read response back to the requester that issued it.
- Optionally zero-fills the RAM after reset before it accepts any requests.

Parameters:
- NumPorts, 4, number of requesters (2..8).
- AddrWidth, 9, word address width (512 x 32 bit).
- DataWidth, 32, fixed data width; matches the SP BIT_WIDTH of 32.
- OutputReg, 1, 1 when the SP is instantiated with READ_MODE=1 (output pipeline register); sets read latency to 1+OutputReg.
- ClearOnReset, 1, 1 zero-fills every word after reset before accepting requests.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, [NumPorts], request valid per requester.
- req_ready_o, out, [NumPorts], request accepted (grant) per requester.
- req_we_i, in, [NumPorts], 1 = write, 0 = read.
- req_addr_i, in, [NumPorts][AddrWidth], word address.
- req_be_i, in, [NumPorts][4], byte write enables (ignored on reads).
- req_wdata_i, in, [NumPorts][32], write data.
- rsp_valid_o, out, [NumPorts], read data valid for requester i (one-cycle pulse, no back-pressure).
- rsp_rdata_o, out, 32, read data, shared across requesters, qualified by rsp_valid_o.
- busy_o, out, 1, high while the clear sequence runs.
- sram_ce_o, out, 1, SP CE.
- sram_oce_o, out, 1, SP OCE (constant 1).
- sram_wre_o, out, 1, SP WRE.
- sram_ad_o, out, 14, SP AD.
- sram_di_o, out, 32, SP DI.
- sram_reset_o, out, 1, SP RESET (constant 0).
- sram_do_i, in, 32, SP DO.

Behaviour:
- Reset values (asynchronous):
  - FSM goes to CLEAR if ClearOnReset=1, else RUN.
  - Round-robin pointer = 0; clear counter = 0; tag pipeline all invalid.
  - rsp_valid_o = 0; busy_o = ClearOnReset.
- FSM CLEAR:
  - Each cycle: sram_ce_o=1, sram_wre_o=1, sram_di_o=0, sram_ad_o={cnt, 1'b0, 4'hF}; cnt increments.
  - cnt == 2^AddrWidth-1: go to RUN the next cycle, busy_o drops.
  - All req_ready_o = 0 throughout.
  - Reset asserted mid-clear restarts the clear from address 0.
- FSM RUN:
  - Grant the first valid requester at or after the pointer, searching upward with wrap from NumPorts-1 to 0.
  - req_ready_o is combinational and one-hot on the grant; all zero when no requester is valid.
  - After a grant, pointer = granted index + 1 (mod NumPorts). The pointer holds when nothing is granted.
- SP drive on grant (same cycle, combinational):
  - sram_ce_o = 1; sram_wre_o = req_we_i.
  - sram_ad_o = {addr, 1'b0, we ? be : 4'h0}; sram_di_o = wdata.
  - No grant: sram_ce_o = 0, sram_wre_o = 0, other SP outputs hold don't-care values (drive 0).
- Read latency:
  - A granted read pushes {valid=1, id} into a shift pipeline of depth L = 1+OutputReg.
  - At stage L, rsp_valid_o[id] = 1 and rsp_rdata_o = sram_do_i.
  - Writes push valid=0 and produce no response.
- Ordering and throughput:
  - Responses return in issue order, one per cycle maximum, at full throughput (back-to-back reads give back-to-back responses).
- Same-address read and write:
  - Read-after-write to the same address on consecutive grants returns the new data (BSRAM write completes at the edge).
  - The arbiter adds no forwarding.
- Requester obligation: a requester keeps valid and its payload stable until ready; the arbiter never drops an accepted request.

Decomposition:
- Package sp_bram_pkg holds:
  - fsm_state_e {CLEAR, RUN};
  - SramAdWidth = 14 and the byte-enable field offset;
  - typedef tag_t = struct {valid, id[$clog2(NumPorts)]}.
- Sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out, purely combinational). It is reused by the register-file arbiters.

Test Plan:
- Clear: release reset with ClearOnReset=1 -> busy_o high for exactly 512 cycles with ad stepping 0x000F, 0x002F, ...; after clear, a read of address 0x1FF returns 0.
- Single port: port 0 writes 0xDEADBEEF to 0x010 with be=4'hF, then reads 0x010 -> rsp_valid_o[0] pulses L cycles after the read grant with data 0xDEADBEEF.
- Byte enable: write 0x11223344 to 0x020, then write 0xAABBCCDD with be=4'b0101 -> reading back gives 0x11BB33DD.
- Fairness: all 4 ports hold valid reads continuously -> grants go 0,1,2,3,0,...; every port receives exactly 25 of the first 100 responses, and each rsp_valid is routed to the correct port.
- Throughput: port 2 issues 8 back-to-back reads of 0x000..0x007 -> 8 consecutive rsp_valid_o[2] pulses carrying the data in address order.
- Reset mid-operation: assert rst_ni during a read in flight and during clear -> no rsp_valid pulse afterwards, pointer = 0, clear restarts at address 0.
